// File: rtl/qft_seq.sv
// Sequential QFT engine: one complex MAC walks all N*N terms of y_j = sum_k x_k*w^(jk).
// Samples stream in, results stream out; the twiddle ROM is a 16-point table decimated by N.
module qft_seq #(
  parameter int unsigned QUBITS   = 2,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_FRAC = 5,
  localparam int unsigned OUT_W   = IN_W + QUBITS + 1 + OUT_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inverse,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [QUBITS-1:0]       out_idx,
  output logic                    busy
);

  localparam int unsigned N      = 2 ** QUBITS;
  localparam int unsigned TW_W   = 12;
  localparam int unsigned PROD_W = IN_W + 13;
  localparam int unsigned ACC_W  = IN_W + QUBITS + 13;
  localparam int unsigned SHIFT  = 10 - OUT_FRAC;
  localparam logic [QUBITS-1:0] LAST = QUBITS'(N - 1);

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  state_e state_q;

  logic [QUBITS-1:0] load_k_q;
  logic              inv_q;
  logic [QUBITS-1:0] j_q;
  logic [QUBITS-1:0] k_q;
  logic              iss_q;

  logic              s1_vld_q;
  logic              s1_first_q;
  logic              s1_last_q;
  logic [QUBITS-1:0] s1_j_q;
  logic              s2_vld_q;
  logic              s2_first_q;
  logic              s2_last_q;
  logic [QUBITS-1:0] s2_j_q;
  logic              done_q;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic signed [OUT_W-1:0] out_re_q;
  logic signed [OUT_W-1:0] out_im_q;
  logic [QUBITS-1:0]       out_idx_q;
  logic [QUBITS-1:0]       out_idx_nxt;

  logic signed [IN_W-1:0]   samp_re [N];
  logic signed [IN_W-1:0]   samp_im [N];
  logic signed [OUT_W-1:0]  res_re [N];
  logic signed [OUT_W-1:0]  res_im [N];

  logic signed [IN_W-1:0]   s1_xr_q;
  logic signed [IN_W-1:0]   s1_xi_q;
  logic signed [TW_W-1:0]   s1_c_q;
  logic signed [TW_W-1:0]   s1_s_q;
  logic signed [PROD_W-1:0] s2_pr_q;
  logic signed [PROD_W-1:0] s2_pi_q;
  logic signed [PROD_W-1:0] pr_d;
  logic signed [PROD_W-1:0] pi_d;
  logic signed [ACC_W-1:0]  acc_re_q;
  logic signed [ACC_W-1:0]  acc_im_q;
  logic signed [ACC_W-1:0]  acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_d;

  logic [QUBITS-1:0]        tw_m;
  logic [3:0]               tw_a;
  logic signed [TW_W-1:0]   tw_c;
  logic signed [TW_W-1:0]   tw_s;

  // round(cos(2*pi*a/16) * 1024) in Q1.10
  function automatic logic signed [TW_W-1:0] cos16(input logic [3:0] a);
    logic signed [TW_W-1:0] v;
    case (a)
      4'd0:        v = 12'sd1024;
      4'd1, 4'd15: v = 12'sd946;
      4'd2, 4'd14: v = 12'sd724;
      4'd3, 4'd13: v = 12'sd392;
      4'd4, 4'd12: v = 12'sd0;
      4'd5, 4'd11: v = -12'sd392;
      4'd6, 4'd10: v = -12'sd724;
      4'd7, 4'd9:  v = -12'sd946;
      default:     v = -12'sd1024;
    endcase
    return v;
  endfunction

  // Twiddle index m = jk mod N, rescaled onto the 16-point circle; sin(a) = cos(a - 4)
  always_comb begin
    tw_m = j_q * k_q;
    tw_a = 4'(tw_m) << (4 - QUBITS);
    tw_c = cos16(tw_a);
    tw_s = cos16(tw_a - 4'd4);
    if (inv_q) begin
      tw_s = -tw_s;
    end
  end

  always_comb begin
    pr_d = PROD_W'(s1_xr_q) * PROD_W'(s1_c_q) - PROD_W'(s1_xi_q) * PROD_W'(s1_s_q);
    pi_d = PROD_W'(s1_xr_q) * PROD_W'(s1_s_q) + PROD_W'(s1_xi_q) * PROD_W'(s1_c_q);
    acc_re_d = (s2_first_q ? '0 : acc_re_q) + ACC_W'(s2_pr_q);
    acc_im_d = (s2_first_q ? '0 : acc_im_q) + ACC_W'(s2_pi_q);
  end

  assign out_idx_nxt = out_idx_q + 1'b1;

  // Datapath storage; contents are don't-care after reset so no reset branch is needed
  always_ff @(posedge clk) begin
    if (in_valid && in_ready_q) begin
      samp_re[load_k_q] <= in_re;
      samp_im[load_k_q] <= in_im;
    end
    s1_xr_q <= samp_re[k_q];
    s1_xi_q <= samp_im[k_q];
    s1_c_q  <= tw_c;
    s1_s_q  <= tw_s;
    s2_pr_q <= pr_d;
    s2_pi_q <= pi_d;
    if (s2_vld_q) begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      if (s2_last_q) begin
        res_re[s2_j_q] <= OUT_W'(acc_re_d >>> SHIFT);
        res_im[s2_j_q] <= OUT_W'(acc_im_d >>> SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      load_k_q    <= '0;
      inv_q       <= 1'b0;
      j_q         <= '0;
      k_q         <= '0;
      iss_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_j_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_j_q      <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      // Term tags travel alongside the datapath registers
      s1_vld_q   <= iss_q;
      s1_first_q <= (k_q == '0);
      s1_last_q  <= (k_q == LAST);
      s1_j_q     <= j_q;
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_j_q     <= s1_j_q;
      done_q     <= s2_vld_q && s2_last_q && (s2_j_q == LAST);

      case (state_q)
        StLoad: begin
          if (in_valid) begin
            if (load_k_q == '0) begin
              inv_q <= inverse;
            end
            load_k_q <= load_k_q + 1'b1;
            if (load_k_q == LAST) begin
              state_q    <= StCompute;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              j_q        <= '0;
              k_q        <= '0;
              iss_q      <= 1'b1;
            end
          end
        end
        StCompute: begin
          if (iss_q) begin
            k_q <= k_q + 1'b1;
            if (k_q == LAST) begin
              j_q <= j_q + 1'b1;
              if (j_q == LAST) begin
                iss_q <= 1'b0;
              end
            end
          end
          if (done_q) begin
            state_q     <= StOutput;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_re_q    <= res_re[0];
            out_im_q    <= res_im[0];
          end
        end
        StOutput: begin
          if (out_ready) begin
            if (out_idx_q == LAST) begin
              state_q     <= StLoad;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              out_idx_q   <= '0;
            end else begin
              out_idx_q <= out_idx_nxt;
              out_re_q  <= res_re[out_idx_nxt];
              out_im_q  <= res_im[out_idx_nxt];
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_qft_seq.sv
// Bench for qft_seq: two instances (2 and 3 qubits) checked against a floating-point DFT model.
module tb_qft_seq;
  localparam int IN_W     = 8;
  localparam int OUT_FRAC = 5;
  localparam int OW2      = IN_W + 2 + 1 + OUT_FRAC;
  localparam int OW3      = IN_W + 3 + 1 + OUT_FRAC;
  localparam real PI      = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n, inverse, in_valid, out_ready, sel;
  logic signed [IN_W-1:0] in_re, in_im;

  logic in_valid2, in_ready2, out_valid2, busy2;
  logic signed [OW2-1:0] out_re2, out_im2;
  logic [1:0] out_idx2;
  logic in_valid3, in_ready3, out_valid3, busy3;
  logic signed [OW3-1:0] out_re3, out_im3;
  logic [2:0] out_idx3;

  logic o_ready, o_valid, o_busy;
  logic signed [OW3-1:0] o_re, o_im;
  logic [2:0] o_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_last = 0;
  int in_r [16];
  int in_i [16];
  longint exp_re [16];
  longint exp_im [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid2 = in_valid && !sel;
  assign in_valid3 = in_valid && sel;

  qft_seq #(.QUBITS(2), .IN_W(IN_W), .OUT_FRAC(OUT_FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid2), .out_ready(out_ready),
    .out_re(out_re2), .out_im(out_im2), .out_idx(out_idx2), .busy(busy2)
  );

  qft_seq #(.QUBITS(3), .IN_W(IN_W), .OUT_FRAC(OUT_FRAC)) dut3 (
    .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid3), .out_ready(out_ready),
    .out_re(out_re3), .out_im(out_im3), .out_idx(out_idx3), .busy(busy3)
  );

  always_comb begin
    if (sel) begin
      o_ready = in_ready3; o_valid = out_valid3; o_busy = busy3;
      o_re = out_re3; o_im = out_im3; o_idx = out_idx3;
    end else begin
      o_ready = in_ready2; o_valid = out_valid2; o_busy = busy2;
      o_re = OW3'(out_re2); o_im = OW3'(out_im2); o_idx = {1'b0, out_idx2};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y_j = sum_k x_k * (c + i*s), twiddles rounded to Q1.10, result floored to OUT_FRAC bits
  function automatic void model(input int n, input bit inv);
    longint ar, ai, c, s;
    real ang;
    for (int j = 0; j < n; j++) begin
      ar = 0;
      ai = 0;
      for (int k = 0; k < n; k++) begin
        ang = 2.0 * PI * real'((j * k) % n) / real'(n);
        c = longint'(1024.0 * $cos(ang));
        s = longint'(1024.0 * $sin(ang));
        if (inv) s = -s;
        ar += in_r[k] * c - in_i[k] * s;
        ai += in_r[k] * s + in_i[k] * c;
      end
      exp_re[j] = ar >>> (10 - OUT_FRAC);
      exp_im[j] = ai >>> (10 - OUT_FRAC);
    end
  endfunction

  // kind 0: delta at position v; 1: constant v on both parts; else random
  task automatic set_frame(input int kind, input int v);
    for (int k = 0; k < 16; k++) begin
      case (kind)
        0: begin in_r[k] = (k == v) ? 1 : 0; in_i[k] = 0; end
        1: begin in_r[k] = v; in_i[k] = v; end
        default: begin
          in_r[k] = int'($urandom_range(0, 255)) - 128;
          in_i[k] = int'($urandom_range(0, 255)) - 128;
        end
      endcase
    end
  endtask

  task automatic load_frame(input int n, input bit inv, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          step();
        end
      end
      in_valid = 1'b1;
      in_re = IN_W'(in_r[k]);
      in_im = IN_W'(in_i[k]);
      inverse = (k == 0) ? inv : 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    t_last = cyc;
    model(n, inv);
    chk("busy_after_load", o_busy, 1);
    chk("in_ready_after_load", o_ready, 0);
  endtask

  task automatic wait_first(input int n, input bit pulse);
    int guard;
    bit bad;
    guard = 0;
    bad = 1'b0;
    while (!o_valid && guard < n * n + 20) begin
      if (o_ready) bad = 1'b1;
      in_valid = pulse ? 1'($urandom) : 1'b0;
      in_re = IN_W'($urandom);
      in_im = IN_W'($urandom);
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("in_ready_low_compute", bad, 0);
    chk("first_valid_latency", cyc - t_last, n * n + 3);
  endtask

  // mode 0: always ready; 1: stall 5 then toggle, with in_valid noise; 2: random ready
  task automatic collect(input int n, input int mode, input int lim);
    int j, guard, vc;
    bit rdy, hs;
    j = 0; guard = 0; vc = 0;
    while (j < lim && guard < 400) begin
      if (o_valid) begin
        chk("out_idx", o_idx, j);
        chk("out_re", o_re, exp_re[j]);
        chk("out_im", o_im, exp_im[j]);
        chk("in_ready_low_output", o_ready, 0);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (vc >= 5) && (vc % 2 == 1);
        default: rdy = 1'($urandom);
      endcase
      if (o_valid) vc++;
      out_ready = rdy;
      in_valid = (mode == 1 && j < n - 1) ? 1'($urandom) : 1'b0;
      hs = o_valid && rdy;
      step();
      guard++;
      if (hs) j++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("results_seen", j, lim);
    if (lim == n) begin
      chk("in_ready_after_out", o_ready, 1);
      chk("out_valid_after_out", o_valid, 0);
      chk("busy_after_out", o_busy, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, o_ready, 1);
    chk({tag, "_out_valid"}, o_valid, 0);
    chk({tag, "_out_re"}, o_re, 0);
    chk({tag, "_out_im"}, o_im, 0);
    chk({tag, "_out_idx"}, o_idx, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic watch_idle(input int cycles);
    bit saw;
    saw = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (o_valid) saw = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("no_valid_after_reset", saw, 0);
  endtask

  task automatic run_frame(input int n, input int kind, input int v, input bit inv,
                           input bit gaps, input int mode);
    set_frame(kind, v);
    load_frame(n, inv, gaps);
    wait_first(n, mode == 1);
    collect(n, mode, n);
  endtask

  initial begin
    rst_n = 1'b0; inverse = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; sel = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk_reset_vals("reset_release");

    run_frame(4, 0, 0, 1'b0, 1'b0, 0);
    run_frame(4, 0, 1, 1'b0, 1'b0, 0);
    run_frame(4, 0, 1, 1'b1, 1'b0, 0);
    run_frame(4, 1, 1, 1'b0, 1'b0, 0);
    run_frame(4, 1, -128, 1'b0, 1'b0, 0);
    run_frame(4, 2, 0, 1'b0, 1'b0, 1);
    for (int f = 0; f < 3; f++) begin
      run_frame(4, 2, 0, 1'($urandom), 1'b1, 2);
    end

    // abort during compute
    set_frame(2, 0);
    load_frame(4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    chk_reset_vals("rst_compute");
    rst_n = 1'b1;
    watch_idle(40);

    // abort during output after two results
    set_frame(2, 0);
    load_frame(4, 1'b1, 1'b0);
    wait_first(4, 1'b0);
    collect(4, 0, 2);
    rst_n = 1'b0;
    step();
    chk_reset_vals("rst_output");
    rst_n = 1'b1;
    watch_idle(30);
    run_frame(4, 2, 0, 1'($urandom), 1'b0, 0);

    sel = 1'b1;
    step();
    run_frame(8, 0, 1, 1'b0, 1'b0, 0);
    run_frame(8, 2, 0, 1'b1, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
